// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: transmit end of the common data bus.
// Each functional unit's completions are held in a small per-source FIFO. One
// head entry per cycle is picked round-robin and registered onto cdb_packet,
// so at most one valid packet is broadcast per cycle and none is lost or repeated.

package cdb_pkg;

    typedef struct packed {
        logic        valid;
        logic [4:0]  Tag;
        logic [31:0] Value;
        logic [31:0] PC;
        logic [31:0] NPC;
        logic [31:0] inst;
        logic [31:0] alu_result;
        logic        take_branch;
        logic        halt;
        logic        illegal;
    } CDB_PACKET;

endpackage

module cdb_broadcaster
    import cdb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 2,
    localparam int SW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash_signal,
    input  logic [NUM_SRC-1:0]         fu_valid,
    input  CDB_PACKET [NUM_SRC-1:0]    fu_packet,
    output logic [NUM_SRC-1:0]         fu_ready,
    output CDB_PACKET                  cdb_packet,
    output logic [SW-1:0]              cdb_src
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] ZERO_PTR = {PW{1'b0}};
    localparam logic [PW-1:0] ONE_PTR  = {{(PW-1){1'b0}}, 1'b1};

    // FIFO storage and bookkeeping, one set per source
    CDB_PACKET      mem_r    [NUM_SRC][FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr_r [NUM_SRC];
    logic [PW-1:0]  wr_ptr_r [NUM_SRC];
    logic [CW-1:0]  count_r  [NUM_SRC];
    logic [SW-1:0]  rr_r;

    logic [NUM_SRC-1:0] req_s;
    logic [NUM_SRC-1:0] push_s;
    logic [NUM_SRC-1:0] pop_s;
    logic               grant_valid_s;
    logic [SW-1:0]      grant_idx_s;
    CDB_PACKET          head_s;
    logic               flush_s;

    // (base + offset) mod NUM_SRC for offsets below NUM_SRC; works for any NUM_SRC
    function automatic logic [SW-1:0] rr_index(input logic [SW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end else begin
            sum = sum;
        end
        return sum[SW-1:0];
    endfunction

    assign flush_s = reset | squash_signal;

    // Ready and request come straight from registered counts, never from the grant
    always_comb begin
        fu_ready = {NUM_SRC{1'b0}};
        req_s    = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            fu_ready[i] = (count_r[i] != FULL_CNT);
            req_s[i]    = (count_r[i] != ZERO_CNT);
        end
    end

    // Round-robin scan starting at rr_r; first non-empty FIFO wins
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {SW{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!grant_valid_s && req_s[rr_index(rr_r, k)]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = rr_index(rr_r, k);
            end else begin
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // Push/pop strobes; a flush suppresses both so nothing moves on that edge
    always_comb begin
        push_s = {NUM_SRC{1'b0}};
        pop_s  = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            push_s[i] = fu_valid[i] & fu_ready[i] & ~flush_s;
            pop_s[i]  = grant_valid_s & (grant_idx_s == SW'(i)) & ~flush_s;
        end
    end

    // Head entry of the winning FIFO, marked live for broadcast
    always_comb begin
        head_s       = mem_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
        head_s.valid = 1'b1;
    end

    // Payload storage; contents need no clearing because counts gate visibility
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= fu_packet[i];
            end
        end
    end

    // FIFO pointers and counts; pointers wrap naturally since depth is a power of 2
    always_ff @(posedge clock) begin
        if (flush_s) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                rd_ptr_r[i] <= ZERO_PTR;
                wr_ptr_r[i] <= ZERO_PTR;
                count_r[i]  <= ZERO_CNT;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + ONE_PTR;
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + ONE_PTR;
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + ONE_CNT;
                    2'b01:   count_r[i] <= count_r[i] - ONE_CNT;
                    default: count_r[i] <= count_r[i];
                endcase
            end
        end
    end

    // Broadcast register, source index and round-robin pointer
    always_ff @(posedge clock) begin
        if (flush_s) begin
            cdb_packet <= '0;
            cdb_src    <= {SW{1'b0}};
            rr_r       <= {SW{1'b0}};
        end else if (grant_valid_s) begin
            cdb_packet <= head_s;
            cdb_src    <= grant_idx_s;
            rr_r       <= rr_index(grant_idx_s, 1);
        end else begin
            cdb_packet.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster (NUM_SRC=4, FIFO_DEPTH=2).
// Expected broadcast sequences below are worked out cycle by cycle by hand.

module tb_cdb_broadcaster;
    import cdb_pkg::*;

    logic            clock;
    logic            reset;
    logic            squash_signal;
    logic [3:0]      fu_valid;
    logic [3:0]      fu_ready;
    CDB_PACKET [3:0] fu_packet;
    CDB_PACKET       cdb_packet;
    logic [1:0]      cdb_src;

    int errors_cnt = 0;
    int checks_cnt = 0;

    cdb_broadcaster #(.NUM_SRC(4), .FIFO_DEPTH(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .squash_signal (squash_signal),
        .fu_valid      (fu_valid),
        .fu_packet     (fu_packet),
        .fu_ready      (fu_ready),
        .cdb_packet    (cdb_packet),
        .cdb_src       (cdb_src)
    );

    initial clock = 1'b0;
    // Free-running 10-time-unit clock
    always #5 clock = ~clock;

    function automatic CDB_PACKET mk_pkt(input logic [4:0] tag, input logic [31:0] value);
        CDB_PACKET p;
        p            = '0;
        p.Tag        = tag;
        p.Value      = value;
        p.PC         = 32'h0000_1000 + {25'd0, tag, 2'b00};
        p.NPC        = p.PC + 32'd4;
        p.inst       = 32'h0000_0013;
        p.alu_result = value ^ 32'hFFFF_FFFF;
        return p;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_cdb(input string name, input logic exp_valid,
                             input logic [4:0] exp_tag, input logic [1:0] exp_src);
        check_val({name, ".valid"}, 64'(cdb_packet.valid), 64'(exp_valid));
        if (exp_valid) begin
            check_val({name, ".tag"}, 64'(cdb_packet.Tag), 64'(exp_tag));
            check_val({name, ".src"}, 64'(cdb_src), 64'(exp_src));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        squash_signal = 1'b0;
        fu_valid      = 4'b1111;
        for (int i = 0; i < 4; i++) fu_packet[i] = mk_pkt(5'(i + 1), 32'h100 + 32'(i));

        // Reset held two cycles while every source offers
        tick();
        tick();
        check_val("rst.valid", 64'(cdb_packet.valid), 64'd0);
        check_val("rst.tag",   64'(cdb_packet.Tag),   64'd0);
        check_val("rst.value", 64'(cdb_packet.Value), 64'd0);
        check_val("rst.src",   64'(cdb_src),          64'd0);
        check_val("rst.ready", 64'(fu_ready),         64'hF);
        reset    = 1'b0;
        fu_valid = 4'b0000;
        tick();
        check_val("rel.ready", 64'(fu_ready), 64'hF);
        check_cdb("rel.idle0", 1'b0, 5'd0, 2'd0);
        tick();
        check_cdb("rel.idle1", 1'b0, 5'd0, 2'd0);

        // Single source latency: offer, idle, broadcast, idle
        fu_packet[2] = mk_pkt(5'd5, 32'hDEAD);
        fu_valid     = 4'b0100;
        tick();
        fu_valid = 4'b0000;
        check_cdb("lat.t1", 1'b0, 5'd0, 2'd0);
        tick();
        check_cdb("lat.t2", 1'b1, 5'd5, 2'd2);
        check_val("lat.value", 64'(cdb_packet.Value), 64'hDEAD);
        check_val("lat.pc",    64'(cdb_packet.PC),    64'h1014);
        tick();
        check_cdb("lat.t3", 1'b0, 5'd0, 2'd0);

        // Squash pulse puts rr back to 0 before the fairness test
        squash_signal = 1'b1;
        tick();
        squash_signal = 1'b0;

        // Round-robin: all four push at once, broadcasts 0,1,2,3
        for (int i = 0; i < 4; i++) fu_packet[i] = mk_pkt(5'(10 + i), 32'hA0 + 32'(i));
        fu_valid = 4'b1111;
        tick();
        fu_valid = 4'b0000;
        check_cdb("rr.t1", 1'b0, 5'd0, 2'd0);
        tick(); check_cdb("rr.s0", 1'b1, 5'd10, 2'd0);
        tick(); check_cdb("rr.s1", 1'b1, 5'd11, 2'd1);
        check_val("rr.s1.value", 64'(cdb_packet.Value), 64'hA1);
        tick(); check_cdb("rr.s2", 1'b1, 5'd12, 2'd2);
        tick(); check_cdb("rr.s3", 1'b1, 5'd13, 2'd3);
        tick(); check_cdb("rr.end", 1'b0, 5'd0, 2'd0);

        // Backpressure on source 1 while source 0 stays non-empty (rr=0 here)
        fu_packet[0] = mk_pkt(5'd20, 32'd20);
        fu_packet[1] = mk_pkt(5'd1, 32'd1);
        fu_valid     = 4'b0011;
        tick();
        check_cdb("bp.e1", 1'b0, 5'd0, 2'd0);
        fu_packet[0] = mk_pkt(5'd21, 32'd21);
        fu_packet[1] = mk_pkt(5'd2, 32'd2);
        tick();
        check_cdb("bp.e2", 1'b1, 5'd20, 2'd0);
        check_val("bp.ready1.full", 64'(fu_ready[1]), 64'd0);
        fu_packet[0] = mk_pkt(5'd22, 32'd22);
        fu_packet[1] = mk_pkt(5'd3, 32'd3);
        tick();
        check_cdb("bp.e3", 1'b1, 5'd1, 2'd1);
        check_val("bp.ready1.free", 64'(fu_ready[1]), 64'd1);
        check_val("bp.ready0.full", 64'(fu_ready[0]), 64'd0);
        fu_valid = 4'b0010;
        tick();
        check_cdb("bp.e4", 1'b1, 5'd21, 2'd0);
        check_val("bp.ready1.full2", 64'(fu_ready[1]), 64'd0);
        fu_valid = 4'b0000;
        tick(); check_cdb("bp.e5", 1'b1, 5'd2, 2'd1);
        tick(); check_cdb("bp.e6", 1'b1, 5'd22, 2'd0);
        tick(); check_cdb("bp.e7", 1'b1, 5'd3, 2'd1);
        tick(); check_cdb("bp.e8", 1'b0, 5'd0, 2'd0);

        // Squash with buffered packets and a concurrent push on source 3
        for (int i = 0; i < 4; i++) fu_packet[i] = mk_pkt(5'(24 + i), 32'(24 + i));
        fu_valid = 4'b1111;
        tick();
        for (int i = 0; i < 4; i++) fu_packet[i] = mk_pkt(5'(28 + i), 32'(28 + i));
        tick();
        squash_signal = 1'b1;
        fu_valid      = 4'b1000;
        fu_packet[3]  = mk_pkt(5'd17, 32'd17);
        tick();
        squash_signal = 1'b0;
        fu_valid      = 4'b0000;
        check_cdb("sq.out", 1'b0, 5'd0, 2'd0);
        check_val("sq.tag",   64'(cdb_packet.Tag),   64'd0);
        check_val("sq.value", 64'(cdb_packet.Value), 64'd0);
        check_val("sq.src",   64'(cdb_src),          64'd0);
        check_val("sq.ready", 64'(fu_ready),         64'hF);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_cdb("sq.quiet", 1'b0, 5'd0, 2'd0);
        end
        fu_packet[3] = mk_pkt(5'd9, 32'h99);
        fu_valid     = 4'b1000;
        tick();
        fu_valid = 4'b0000;
        check_cdb("sq.post.t1", 1'b0, 5'd0, 2'd0);
        tick();
        check_cdb("sq.post.t2", 1'b1, 5'd9, 2'd3);
        check_val("sq.post.value", 64'(cdb_packet.Value), 64'h99);
        tick();
        check_cdb("sq.post.t3", 1'b0, 5'd0, 2'd0);

        // Source 0 streams Tags 0..7 with valid held high; pointers wrap
        fu_valid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            fu_packet[0] = mk_pkt(5'(k), 32'h500 + 32'(k));
            check_val("st.ready", 64'(fu_ready[0]), 64'd1);
            tick();
            if (k == 0) check_cdb("st.first", 1'b0, 5'd0, 2'd0);
            else        check_cdb("st.bcast", 1'b1, 5'(k - 1), 2'd0);
        end
        fu_valid = 4'b0000;
        tick();
        check_cdb("st.last", 1'b1, 5'd7, 2'd0);
        check_val("st.last.value", 64'(cdb_packet.Value), 64'h507);
        tick();
        check_cdb("st.end", 1'b0, 5'd0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule

// File: doc/cdb_broadcaster.md
# cdb_broadcaster

Transmit end of the common data bus. Collects completion packets from the functional units, buffers each unit's output in a small per-source FIFO, and selects one packet per cycle round-robin. The selected packet is driven from a register onto `CDB_packet_in` of the ROB and the RS tag-match logic. This block owns the guarantee that exactly one valid `CDB_PACKET` appears per cycle at most, with no loss and no duplication.

## Interface
- `NUM_SRC`, default 4: number of functional-unit completion sources.
- `FIFO_DEPTH`, default 2: entries per source FIFO (power of 2, ≥2).
- `clock` input 1: sole clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high; clears all state.
- `squash_signal` input 1: synchronous flush from branch-miss retire.
- `fu_valid` input `NUM_SRC`: source i offers `fu_packet[i]` this cycle.
- `fu_packet` input `NUM_SRC` x `CDB_PACKET`: completion payload (Tag, Value, PC, NPC, inst, alu_result, take_branch, halt, illegal). The `.valid` field is ignored; `fu_valid` governs.
- `fu_ready` output `NUM_SRC`: source i's FIFO can accept this cycle.
- `cdb_packet` output `CDB_PACKET`: registered broadcast; `.valid` marks a live packet.
- `cdb_src` output `$clog2(NUM_SRC)`: index of the source that produced the current `cdb_packet`.

## Operation
- Per-source FIFO: circular storage with read and write pointers, plus a count of width `$clog2(FIFO_DEPTH)+1`.
- Ready: `fu_ready[i] = (count[i] != FIFO_DEPTH)`. It depends only on registered count, with no combinational path from the grant.
- Push: occurs when `fu_valid[i] && fu_ready[i] && !squash_signal`. Data is written at the write pointer, which then increments with wrap.
- Arbitration:
  - Requesters are the FIFOs with `count[i] != 0`.
  - The round-robin pointer `rr` (reset 0) holds the highest-priority index.
  - Scan order is `rr, rr+1, …, NUM_SRC-1, 0, …, rr-1`, modulo `NUM_SRC`.
  - The first requester in scan order wins (index `g`).
- Pop: the winner's head entry is popped. On the next edge, the following load:
  - `cdb_packet` gets the head entry with `.valid=1`.
  - `cdb_src` gets `g`.
  - `rr` gets `(g+1) mod NUM_SRC`.
- No winner: `cdb_packet.valid` is loaded 0, and `cdb_src` and `rr` hold.
- Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance. This is legal when count is 1..FIFO_DEPTH-1. On a full FIFO, a push is impossible because ready is 0.
- No bypass: a packet pushed into an empty FIFO becomes eligible the cycle after the push.
- Squash: all of the following reset on the edge where `squash_signal=1`.
  - All FIFO pointers and counts go to 0.
  - Any offered push is dropped; the pop does not occur.
  - `rr` goes to 0.
  - `cdb_packet` goes to 0 (so `.valid=0`) and `cdb_src` goes to 0.
- Priority: `reset` takes priority over `squash_signal`. Their effect is identical.

## Timing
- Reset values:
  - `cdb_packet` = all-zero, `cdb_src` = 0.
  - `fu_ready` = all 1, since counts are 0.
  - Internal `rr` = 0; all counts and pointers = 0.
- Latency: a push accepted at edge t puts the packet on `cdb_packet` at the earliest after edge t+1, i.e. 2 cycles from offer to broadcast.
- `cdb_packet.valid` pulses for exactly one cycle per popped entry.
- Throughput: 1 broadcast per cycle aggregate. Each source is guaranteed at least 1 grant every `NUM_SRC` cycles while non-empty.
- Handshake: a source must hold `fu_packet[i]` stable while `fu_valid[i]=1 && fu_ready[i]=0`. The transfer completes in the cycle where both are 1.
- Ordering: per-source order is FIFO. There is no cross-source ordering guarantee.
- Reset mid-operation: buffered packets are discarded. The output is 0 the following cycle.

## Test plan
- **Reset:** assert `reset` 2 cycles with `fu_valid=4'b1111` → `cdb_packet.valid=0`, `fu_ready=4'b1111` after release, and nothing broadcast.
- **Single source latency:** push Tag=5, Value=32'hDEAD on source 2 at cycle 10 → `cdb_packet` Tag=5, Value=32'hDEAD, `valid=1` at cycle 12. `cdb_src=2`, with `valid=0` at cycle 13.
- **Round-robin fairness:** all 4 sources push one packet each in the same cycle, `rr=0` → broadcasts come from `cdb_src` 0,1,2,3 on four consecutive cycles. Then `valid=0`.
- **Backpressure and order:**
  - Source 1 pushes Tags 1,2,3 on consecutive cycles while source 0 keeps its FIFO non-empty.
  - `fu_ready[1]` drops to 0 with count=2, and the Tag-3 offer is held until ready.
  - Output order from source 1 is exactly 1,2,3, with no drops or duplicates.
- **Squash:** fill all FIFOs to 2, then assert `squash_signal` for 1 cycle together with a new push on source 3.
  - Next cycle: `cdb_packet.valid=0`, all `fu_ready=1`, and subsequent cycles broadcast nothing.
  - A post-squash push on source 3 then appears with `cdb_src=3` after 2 cycles.
- **Simultaneous push/pop and wrap:** source 0 alone streams 8 packets with Tags 0..7, `fu_valid` held high → after the first 2-cycle latency, 8 consecutive broadcast cycles with Tags 0..7 in order. `fu_ready[0]` stays 1 throughout, and the pointers wrap correctly.
